vernam_decipher: RTL and testbench

Hardware receive end of the Vernam link. It buffers one-time-pad key bytes pushed by the random-number PicoBlaze over its port strobe, and accepts ciphertext bytes on a valid/ready stream. It XORs each ciphertext byte with the oldest unused key byte and presents the plaintext on a registered valid/ready output. After each delivered byte it raises a set/ack interrupt flag for the consuming PicoBlaze.

---
 rtl/vernam_decipher.sv | 201 ++++++++++++++++++++
 tb/tb_vernam_decipher.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vernam_decipher.sv
// vernam_decipher: receive end of the Vernam link.
// Key bytes from the key generator are buffered in a small circular FIFO.
// Each accepted ciphertext byte is XORed with the oldest unused key byte and
// presented on a registered valid/ready output. Every delivered byte raises a
// set/ack interrupt flag and increments a delivered-byte counter.
// Optional build macro: VERNAM_DEC_OVERFLOW_EN enables a sticky key_overflow
// flag. Dropped key writes then also raise irq.
module vernam_decipher #(
    parameter int KEY_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         key_wr,
    input  logic [7:0]                   key_data,
    output logic                         key_full,
    output logic [$clog2(KEY_DEPTH):0]   key_level,
    input  logic                         cipher_valid,
    input  logic [7:0]                   cipher_data,
    output logic                         cipher_ready,
    output logic                         plain_valid,
    output logic [7:0]                   plain_data,
    input  logic                         plain_ready,
    output logic                         irq,
    input  logic                         irq_ack,
    output logic [CNT_W-1:0]             byte_count,
    output logic                         key_overflow
);

    localparam int PTR_W = $clog2(KEY_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // The output register either holds a pending plaintext byte or it does not.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [7:0]       key_mem_r [KEY_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] count_r;
    logic [LVL_W-1:0] count_next_s;
    logic [0:0]       state_r;
    logic [0:0]       state_next_s;
    logic [7:0]       plain_data_r;
    logic             irq_r;
    logic             irq_next_s;
    logic             irq_set_s;
    logic [CNT_W-1:0] byte_count_r;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             accept_s;
    logic             deliver_s;
    logic             push_s;

    assign fifo_full_s  = (count_r == LVL_W'(KEY_DEPTH));
    assign fifo_empty_s = (count_r == {LVL_W{1'b0}});

    assign plain_valid  = (state_r == ST_FULL);
    assign plain_data   = plain_data_r;
    assign irq          = irq_r;
    assign byte_count   = byte_count_r;
    assign key_full     = fifo_full_s;
    assign key_level    = count_r;

    // A new byte may enter only when a key is buffered and the output slot is
    // free or being emptied this cycle; cipher_valid is deliberately not used.
    assign cipher_ready = !fifo_empty_s && (!plain_valid || plain_ready);

    assign accept_s  = cipher_valid && cipher_ready;
    assign deliver_s = plain_valid && plain_ready;

    // A full FIFO still takes a key write when a pop frees the slot this cycle.
    assign push_s    = key_wr && (!fifo_full_s || accept_s);

`ifdef VERNAM_DEC_OVERFLOW_EN
    logic drop_s;
    logic key_overflow_r;

    assign drop_s       = key_wr && fifo_full_s && !accept_s;
    assign irq_set_s    = deliver_s || drop_s;
    assign key_overflow = key_overflow_r;

    // Sticky record of any key byte dropped on a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_overflow_r <= 1'b0;
        end else if (drop_s) begin
            key_overflow_r <= 1'b1;
        end else begin
            key_overflow_r <= key_overflow_r;
        end
    end
`else
    assign irq_set_s    = deliver_s;
    assign key_overflow = 1'b0;
`endif

    // Occupancy tracks push/pop; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next_s = count_r;
        if (push_s && !accept_s) begin
            count_next_s = count_r + LVL_W'(1);
        end else if (!push_s && accept_s) begin
            count_next_s = count_r - LVL_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Output slot sequencing: refill wins over emptying in the same cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver_s && !accept_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // Acknowledge has priority over a same-cycle set.
    always_comb begin
        irq_next_s = irq_r;
        if (irq_ack) begin
            irq_next_s = 1'b0;
        end else if (irq_set_s) begin
            irq_next_s = 1'b1;
        end else begin
            irq_next_s = irq_r;
        end
    end

    // Key storage; buffered bytes are discarded on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < KEY_DEPTH; i++) begin
                key_mem_r[i] <= 8'h00;
            end
        end else if (push_s) begin
            key_mem_r[wr_ptr_r] <= key_data;
        end else begin
            key_mem_r[wr_ptr_r] <= key_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_r <= push_s   ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
            rd_ptr_r <= accept_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
            count_r  <= count_next_s;
        end
    end

    // Output slot state and decrypted byte register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_EMPTY;
            plain_data_r <= 8'h00;
        end else if (accept_s) begin
            state_r      <= state_next_s;
            plain_data_r <= cipher_data ^ key_mem_r[rd_ptr_r];
        end else begin
            state_r      <= state_next_s;
            plain_data_r <= plain_data_r;
        end
    end

    // Interrupt flag and delivered-byte counter (counter wraps to zero).
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_r        <= 1'b0;
            byte_count_r <= {CNT_W{1'b0}};
        end else if (deliver_s) begin
            irq_r        <= irq_next_s;
            byte_count_r <= byte_count_r + CNT_W'(1);
        end else begin
            irq_r        <= irq_next_s;
            byte_count_r <= byte_count_r;
        end
    end

endmodule

// File: tb/tb_vernam_decipher.sv
// Self-checking bench for vernam_decipher (default parameters).
// Reference model: a key queue plus the expected output registers, advanced
// once per clock from the current inputs.
module tb_vernam_decipher;

`ifdef VERNAM_DEC_OVERFLOW_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        key_wr;
    logic [7:0]  key_data;
    logic        key_full;
    logic [2:0]  key_level;
    logic        cipher_valid;
    logic [7:0]  cipher_data;
    logic        cipher_ready;
    logic        plain_valid;
    logic [7:0]  plain_data;
    logic        plain_ready;
    logic        irq;
    logic        irq_ack;
    logic [15:0] byte_count;
    logic        key_overflow;

    int checks;
    int errors;

    // Reference model state
    logic [7:0]  m_keys[$];
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_irq;
    logic [15:0] m_cnt;
    logic        m_ovf;

    vernam_decipher #(.KEY_DEPTH(4), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_wr       (key_wr),
        .key_data     (key_data),
        .key_full     (key_full),
        .key_level    (key_level),
        .cipher_valid (cipher_valid),
        .cipher_data  (cipher_data),
        .cipher_ready (cipher_ready),
        .plain_valid  (plain_valid),
        .plain_data   (plain_data),
        .plain_ready  (plain_ready),
        .irq          (irq),
        .irq_ack      (irq_ack),
        .byte_count   (byte_count),
        .key_overflow (key_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_ready();
        return (m_keys.size() != 0) && (!m_valid || plain_ready);
    endfunction

    function automatic logic [31:0] dut_vec();
        return {plain_valid, plain_data, irq, byte_count, key_overflow,
                key_full, key_level, cipher_ready};
    endfunction

    function automatic logic [31:0] model_vec();
        logic [2:0] lvl;
        lvl = 3'(m_keys.size());
        return {m_valid, m_data, m_irq, m_cnt, m_ovf,
                (m_keys.size() == DEPTH), lvl, m_ready()};
    endfunction

    // Advance the model by one clock using the inputs currently applied,
    // then move to 1 time unit after the rising edge.
    task automatic tick();
        bit acc, del, drop;
        logic [7:0] k;
        acc  = cipher_valid && m_ready();
        del  = m_valid && plain_ready;
        drop = key_wr && (m_keys.size() == DEPTH) && !acc;
        if (reset) begin
            m_keys.delete();
            m_valid = 1'b0; m_data = 8'h00; m_irq = 1'b0;
            m_cnt = 16'h0000; m_ovf = 1'b0;
        end else begin
            if (acc) begin
                k = m_keys.pop_front();
                m_data = cipher_data ^ k;
            end
            if (key_wr && !drop) m_keys.push_back(key_data);
            if (del) m_cnt = m_cnt + 16'd1;
            if (irq_ack) m_irq = 1'b0;
            else if (del || (OVF && drop)) m_irq = 1'b1;
            if (OVF && drop) m_ovf = 1'b1;
            if (acc) m_valid = 1'b1;
            else if (del) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; key_wr = 1'b0; key_data = 8'h00;
        cipher_valid = 1'b0; cipher_data = 8'h00;
        plain_ready = 1'b0; irq_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", dut_vec(), 32'h0000_0000);
        end
    endtask

    task automatic test_basic();
        do_reset();
        key_wr = 1'b1; key_data = 8'h5A; tick();
        key_data = 8'hFF; tick();
        key_wr = 1'b0;
        plain_ready = 1'b1; cipher_valid = 1'b1; cipher_data = 8'h12; tick();
        checks++;
        if ({plain_valid, plain_data} !== {1'b1, 8'h48}) begin
            errors++;
            $display("FAIL basic_first got %b/%h exp 1/48", plain_valid, plain_data);
        end
        cipher_data = 8'h00; tick();
        checks++;
        if ({plain_valid, plain_data} !== {1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL basic_second got %b/%h exp 1/ff", plain_valid, plain_data);
        end
        cipher_valid = 1'b0; tick();
        checks++;
        if ({plain_valid, byte_count, key_level, irq} !== {1'b0, 16'd2, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL basic_end got v=%b cnt=%0d lvl=%0d irq=%b exp v=0 cnt=2 lvl=0 irq=1",
                     plain_valid, byte_count, key_level, irq);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL basic_model got %h exp %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_starve();
        cipher_valid = 1'b1; cipher_data = 8'h33; plain_ready = 1'b1;
        #1;
        checks++;
        if (cipher_ready !== 1'b0) begin
            errors++;
            $display("FAIL starve_ready got %b exp 0", cipher_ready);
        end
        key_wr = 1'b1; key_data = 8'h0F; tick();
        key_wr = 1'b0;
        checks++;
        if (cipher_ready !== 1'b1) begin
            errors++;
            $display("FAIL starve_ready_after_key got %b exp 1", cipher_ready);
        end
        tick();
        checks++;
        if ({plain_valid, plain_data} !== {1'b1, 8'h3C}) begin
            errors++;
            $display("FAIL starve_plain got %b/%h exp 1/3c", plain_valid, plain_data);
        end
        cipher_valid = 1'b0; tick();
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL starve_model got %h exp %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] k1, k2, c2;
        k1 = 8'($urandom); k2 = 8'($urandom); c2 = 8'($urandom);
        key_wr = 1'b1; key_data = k1; tick();
        key_data = k2; tick();
        key_wr = 1'b0;
        plain_ready = 1'b0; cipher_valid = 1'b1; cipher_data = 8'hA5 ^ k1; tick();
        cipher_data = c2;
        #1;
        checks++;
        if (cipher_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready got %b exp 0", cipher_ready);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({plain_valid, plain_data, key_level} !== {1'b1, 8'hA5, 3'd1}) begin
            errors++;
            $display("FAIL bp_hold got %b/%h lvl=%0d exp 1/a5 lvl=1",
                     plain_valid, plain_data, key_level);
        end
        plain_ready = 1'b1;
        #1;
        checks++;
        if (cipher_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready got %b exp 1", cipher_ready);
        end
        tick();
        checks++;
        if ({plain_valid, plain_data, key_level} !== {1'b1, c2 ^ k2, 3'd0}) begin
            errors++;
            $display("FAIL bp_b2b got %b/%h lvl=%0d exp 1/%h lvl=0",
                     plain_valid, plain_data, key_level, c2 ^ k2);
        end
        cipher_valid = 1'b0; tick();
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL bp_model got %h exp %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        key_wr = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            key_data = 8'($urandom); tick();
        end
        checks++;
        if ({key_full, key_level} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL ovf_fill got full=%b lvl=%0d exp full=1 lvl=4", key_full, key_level);
        end
        key_data = 8'h77; tick();
        key_wr = 1'b0;
        checks++;
        if ({key_full, key_level, key_overflow, irq} !== {1'b1, 3'd4, OVF, OVF}) begin
            errors++;
            $display("FAIL ovf_drop got full=%b lvl=%0d ovf=%b irq=%b exp 1 4 %b %b",
                     key_full, key_level, key_overflow, irq, OVF, OVF);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] c;
        plain_ready = 1'b1; cipher_valid = 1'b1; cipher_data = 8'($urandom);
        key_wr = 1'b1; key_data = 8'h99; tick();
        key_wr = 1'b0;
        checks++;
        if (key_level !== 3'd4) begin
            errors++;
            $display("FAIL fpp_level got %0d exp 4", key_level);
        end
        for (int i = 0; i < 3; i++) begin
            cipher_data = 8'($urandom); tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL fpp_model%0d got %h exp %h", i, dut_vec(), model_vec());
            end
        end
        c = 8'($urandom);
        cipher_data = c; tick();
        checks++;
        if ({plain_valid, plain_data} !== {1'b1, c ^ 8'h99}) begin
            errors++;
            $display("FAIL fpp_key99 got %b/%h exp 1/%h", plain_valid, plain_data, c ^ 8'h99);
        end
        cipher_valid = 1'b0; tick();
    endtask

    task automatic test_irq_ack();
        logic [15:0] cnt0;
        key_wr = 1'b1; key_data = 8'($urandom); tick();
        key_wr = 1'b0;
        plain_ready = 1'b1; cipher_valid = 1'b1; cipher_data = 8'($urandom); tick();
        cipher_valid = 1'b0;
        checks++;
        if ({plain_valid, irq} !== 2'b11) begin
            errors++;
            $display("FAIL ack_setup got v=%b irq=%b exp 1 1", plain_valid, irq);
        end
        cnt0 = byte_count;
        irq_ack = 1'b1; tick();
        irq_ack = 1'b0;
        checks++;
        if ({irq, plain_valid, byte_count} !== {1'b0, 1'b0, cnt0 + 16'd1}) begin
            errors++;
            $display("FAIL ack_wins got irq=%b v=%b cnt=%0d exp 0 0 %0d",
                     irq, plain_valid, byte_count, cnt0 + 16'd1);
        end
    endtask

    task automatic test_reset_midop();
        key_wr = 1'b1; key_data = 8'($urandom); tick();
        key_data = 8'($urandom); tick();
        key_wr = 1'b0;
        plain_ready = 1'b0; cipher_valid = 1'b1; cipher_data = 8'($urandom); tick();
        plain_ready = 1'b1; cipher_data = 8'($urandom); tick();
        checks++;
        if ({plain_valid, irq} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_setup got v=%b irq=%b exp 1 1", plain_valid, irq);
        end
        reset = 1'b1; key_wr = 1'b1; key_data = 8'h42; cipher_valid = 1'b1; tick();
        idle_inputs();
        checks++;
        if (dut_vec() !== 32'h0000_0000) begin
            errors++;
            $display("FAIL midrst_state got %h exp %h", dut_vec(), 32'h0000_0000);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 299) == 0);
            key_wr       = ($urandom_range(0, 99) < 45);
            key_data     = 8'($urandom);
            cipher_valid = ($urandom_range(0, 99) < 60);
            cipher_data  = 8'($urandom);
            plain_ready  = ($urandom_range(0, 99) < 70);
            irq_ack      = ($urandom_range(0, 99) < 20);
            #1;
            checks++;
            if (cipher_ready !== m_ready()) begin
                errors++;
                $display("FAIL rand_ready cyc %0d got %b exp %b", i, cipher_ready, m_ready());
            end
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL rand_state cyc %0d got %h exp %h", i, dut_vec(), model_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_valid = 1'b0; m_data = 8'h00; m_irq = 1'b0; m_cnt = 16'h0000; m_ovf = 1'b0;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_starve();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_irq_ack();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
